// File: rtl/seg_scan_display_pkg.sv
// rtl/seg_scan_display_pkg.sv - shared constants for the multiplexed seven-segment scanner
// Holds the display mode encodings, the blank and lamp-test segment patterns
// and the 16-entry hex glyph table. Segment vectors are ordered g..a and are
// active-low (0 = segment lit).
package seg_scan_display_pkg;

   typedef enum logic [1:0] {
      MODE_VALUE = 2'b00,
      MODE_TEST  = 2'b01,
      MODE_OFF   = 2'b10,
      MODE_LAMP  = 2'b11
   } mode_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_LAMP  = 7'b0000000;

   // Entry n is the glyph for nibble value n.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to seven-segment glyph decoder
// Ports:
//   nibble : 4-bit value to show
//   seg    : 7-bit active-low segment pattern, ordered g..a
module seg_hex_decode
   import seg_scan_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed seven-segment display scanner
// Lights one digit at a time for CLK_DIV cycles, cycling through N_DIGITS.
// New values are captured into a pending register on load and only copied
// into the displayed register at the frame wrap, so a frame never tears.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   data_in     : value to display, nibble k drives digit k (digit 0 rightmost)
//   load        : one-cycle capture strobe for data_in
//   mode        : 00 value, 01 test counter, 10 blank, 11 lamp test
//   blank_en    : leading-zero blanking in value mode
//   hex         : registered active-low segments g..a
//   hex_on      : registered active-low one-hot digit enables
//   frame_done  : one-cycle pulse after the scan wraps back to digit 0
module seg_scan_display
   import seg_scan_display_pkg::*;
#(
   parameter int N_DIGITS = 8,
   parameter int CLK_DIV  = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic                  load,
   input  logic [1:0]            mode,
   input  logic                  blank_en,
   output logic [6:0]            hex,
   output logic [N_DIGITS-1:0]   hex_on,
   output logic                  frame_done
);

   localparam int W      = 4 * N_DIGITS;
   localparam int SCAN_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DIV_W  = $clog2(CLK_DIV);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic [W-1:0]        pend_q, pend_d;
   logic [W-1:0]        disp_q, disp_d;
   logic [W-1:0]        tcnt_q, tcnt_d;
   logic [6:0]          hex_q, hex_d;
   logic [N_DIGITS-1:0] hex_on_q, hex_on_d;
   logic                frame_done_q, frame_done_d;

   logic                div_end;
   logic                scan_end;
   logic                wrap;
   mode_e               mode_sel;
   logic [W-1:0]        src_word;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic [SCAN_W-1:0]   top_idx;
   logic                lead_blank;

   assign mode_sel = mode_e'(mode);

   always_comb begin
      div_end  = (div_q == DIV_W'(CLK_DIV - 1));
      scan_end = (scan_q == SCAN_W'(N_DIGITS - 1));
      wrap     = div_end && scan_end;

      div_d  = div_end ? '0 : div_q + DIV_W'(1);
      scan_d = scan_q;
      if (div_end) begin
         scan_d = scan_end ? '0 : scan_q + SCAN_W'(1);
      end

      // Swap uses the pending value as it was before this edge, so a load
      // landing on the wrap cycle waits for the next frame.
      pend_d       = load ? data_in : pend_q;
      disp_d       = wrap ? pend_q : disp_q;
      tcnt_d       = wrap ? tcnt_q + W'(1) : tcnt_q;
      frame_done_d = wrap;
   end

   // Only one decoder: the nibble for the scanned digit is selected first.
   always_comb begin
      src_word = (mode_sel == MODE_TEST) ? tcnt_q : disp_q;
      nibble   = src_word[4*int'(scan_q) +: 4];
   end

   seg_hex_decode u_decode (
      .nibble (nibble),
      .seg    (glyph)
   );

   // Highest nonzero digit of the displayed value; stays 0 for an all-zero
   // value so digit 0 always shows.
   always_comb begin
      top_idx = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (disp_q[4*k +: 4] != 4'h0) begin
            top_idx = SCAN_W'(k);
         end
      end
      lead_blank = blank_en && (scan_q > top_idx);
   end

   always_comb begin
      hex_d = SEG_BLANK;
      case (mode_sel)
         MODE_VALUE: hex_d = lead_blank ? SEG_BLANK : glyph;
         MODE_TEST:  hex_d = glyph;
         MODE_OFF:   hex_d = SEG_BLANK;
         MODE_LAMP:  hex_d = SEG_LAMP;
         default:    hex_d = SEG_BLANK;
      endcase
      hex_on_d = (mode_sel == MODE_OFF) ? '1 : ~(N_DIGITS'(1) << scan_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q        <= '0;
         scan_q       <= '0;
         pend_q       <= '0;
         disp_q       <= '0;
         tcnt_q       <= '0;
         hex_q        <= SEG_BLANK;
         hex_on_q     <= '1;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         scan_q       <= scan_d;
         pend_q       <= pend_d;
         disp_q       <= disp_d;
         tcnt_q       <= tcnt_d;
         hex_q        <= hex_d;
         hex_on_q     <= hex_on_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign hex        = hex_q;
   assign hex_on     = hex_on_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - self-checking bench for seg_scan_display
module tb_seg_scan_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] data_in = '0;
   logic        load = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        blank_en = 1'b0;
   logic [6:0]  hex;
   logic [3:0]  hex_on;
   logic        frame_done;

   // Small instance whose 4-bit test counter wraps quickly.
   logic [3:0]  data_s = '0;
   logic        load_s = 1'b0;
   logic [1:0]  mode_s = 2'b01;
   logic        blank_s = 1'b0;
   logic [6:0]  hex_s;
   logic [0:0]  hex_on_s;
   logic        fd_s;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [6:0] hex;
      logic [3:0] hon;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   seg_scan_display #(.N_DIGITS(4), .CLK_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .load       (load),
      .mode       (mode),
      .blank_en   (blank_en),
      .hex        (hex),
      .hex_on     (hex_on),
      .frame_done (frame_done)
   );

   seg_scan_display #(.N_DIGITS(1), .CLK_DIV(2)) dut_s (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_s),
      .load       (load_s),
      .mode       (mode_s),
      .blank_en   (blank_s),
      .hex        (hex_s),
      .hex_on     (hex_on_s),
      .frame_done (fd_s)
   );

   function automatic logic [6:0] gl(input logic [3:0] n);
      case (n)
         4'h0: gl = 7'b1000000;
         4'h1: gl = 7'b1111001;
         4'h2: gl = 7'b0100100;
         4'h3: gl = 7'b0110000;
         4'h4: gl = 7'b0011001;
         4'h5: gl = 7'b0010010;
         4'h6: gl = 7'b0000010;
         4'h7: gl = 7'b1111000;
         4'h8: gl = 7'b0000000;
         4'h9: gl = 7'b0010000;
         4'hA: gl = 7'b0001000;
         4'hB: gl = 7'b0000011;
         4'hC: gl = 7'b1000110;
         4'hD: gl = 7'b0100001;
         4'hE: gl = 7'b0000110;
         default: gl = 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Expected frame: one entry per digit, in scan order.
   task automatic push_frame(input logic [15:0] val, input logic [1:0] md, input logic bl);
      int   top;
      exp_t e;
      top = 0;
      for (int k = 0; k < 4; k++) begin
         if (val[4*k +: 4] != 4'h0) top = k;
      end
      for (int d = 0; d < 4; d++) begin
         e.hon = ~(4'b0001 << d);
         case (md)
            2'b00:   e.hex = (bl && d > top) ? 7'b1111111 : gl(val[4*d +: 4]);
            2'b01:   e.hex = gl(val[4*d +: 4]);
            2'b10:   begin e.hex = 7'b1111111; e.hon = 4'hF; end
            default: e.hex = 7'b0000000;
         endcase
         sb_q.push_back(e);
      end
   endtask

   // Checks the 16 cycles of one frame starting at digit 0, optionally
   // pulsing load at cycle indices la and lb.
   task automatic run_frame(input int la, input logic [15:0] da,
                            input int lb, input logic [15:0] db);
      exp_t e;
      e = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i % 4 == 0) begin
            checks++;
            assert (sb_q.size() > 0) else begin
               errors++;
               $error("FAIL sb_empty obs=0 exp=4");
            end
            if (sb_q.size() > 0) e = sb_q.pop_front();
         end
         chk("hex", hex, e.hex);
         chk("hex_on", 7'(hex_on), 7'(e.hon));
         chk("frame_done", 7'(frame_done), 7'(i == 15));
         load = (i == la) || (i == lb);
         if (i == la) data_in = da;
         else if (i == lb) data_in = db;
      end
      load = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_hex", hex, 7'b1111111);
      chk("rst_hex_on", 7'(hex_on), 7'h0F);
      chk("rst_fd", 7'(frame_done), 7'h00);
      load = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_fd_s();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fd_s && n < 10);
      chk("fd_s_seen", 7'(fd_s), 7'h01);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      push_frame(16'h0000, 2'b00, 1'b0); run_frame(-1, '0, -1, '0);
      push_frame(16'h0000, 2'b00, 1'b0); run_frame(6, 16'h1A3F, -1, '0);
      push_frame(16'h1A3F, 2'b00, 1'b0); run_frame(-1, '0, -1, '0);
      blank_en = 1'b1;
      push_frame(16'h1A3F, 2'b00, 1'b1); run_frame(2, 16'h0001, 9, 16'h0002);
      push_frame(16'h0002, 2'b00, 1'b1); run_frame(14, 16'h00C0, -1, '0);
      push_frame(16'h0002, 2'b00, 1'b1); run_frame(-1, '0, -1, '0);
      push_frame(16'h00C0, 2'b00, 1'b1); run_frame(3, 16'h0000, -1, '0);
      push_frame(16'h0000, 2'b00, 1'b1); run_frame(-1, '0, -1, '0);
      mode = 2'b10;
      push_frame(16'h0000, 2'b10, 1'b0); run_frame(5, 16'h5555, -1, '0);
      mode = 2'b11;
      push_frame(16'h0000, 2'b11, 1'b0); run_frame(-1, '0, -1, '0);
      mode = 2'b00; blank_en = 1'b0;
      push_frame(16'h5555, 2'b00, 1'b0); run_frame(-1, '0, -1, '0);
      mode = 2'b01;
      push_frame(16'h000B, 2'b01, 1'b0); run_frame(-1, '0, -1, '0);
      push_frame(16'h000C, 2'b01, 1'b0); run_frame(-1, '0, -1, '0);

      // Reset in cycle 7 of a frame with a load still pending.
      mode = 2'b00;
      @(negedge clk);
      @(negedge clk); load = 1'b1; data_in = 16'h7777;
      @(negedge clk); load = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      do_reset();
      push_frame(16'h0000, 2'b00, 1'b0); run_frame(-1, '0, -1, '0);
      push_frame(16'h0000, 2'b00, 1'b0); run_frame(-1, '0, -1, '0);
      mode = 2'b01;
      push_frame(16'h0002, 2'b01, 1'b0); run_frame(-1, '0, -1, '0);

      // Test-counter wrap on the single-digit instance.
      @(negedge clk);
      do_reset();
      repeat (15) wait_fd_s();
      @(negedge clk);
      chk("small_hex_F", hex_s, 7'b0001110);
      chk("small_hex_on", 7'(hex_on_s), 7'h00);
      wait_fd_s();
      @(negedge clk);
      chk("small_hex_wrap0", hex_s, 7'b1000000);

      chk("sb_drained", 7'(sb_q.size()), 7'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 Parameter CLK_DIV, default 50000, clock cycles each digit stays lit (legal >= 2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  4*N_DIGITS  value to display, nibble k -> digit k (digit 0 = rightmost).
REQ-006 load  input  1  one-cycle strobe, requests capture of data_in.
REQ-007 mode  input  2  00 value, 01 test counter, 10 blank, 11 lamp test.
REQ-008 blank_en  input  1  leading-zero blanking enable (mode 00 only).
REQ-009 hex  output  7  segments g..a, active-low, registered.
REQ-010 hex_on  output  N_DIGITS  digit enables, active-low one-hot, registered.
REQ-011 frame_done  output  1  one-cycle pulse when scan wraps from digit N_DIGITS-1 to 0.

Function
REQ-012 Divider counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and scan index advances by 1.
REQ-013 Scan index counts 0..N_DIGITS-1 and wraps to 0; frame_done asserts in the cycle after the wrap for exactly one cycle.
REQ-014 hex_on SHALL have exactly one bit low, bit = scan index, in modes 00, 01, 11; all ones in mode 10.
REQ-015 load SHALL capture data_in into a pending register in the cycle it is high; load is always accepted, no backpressure.
REQ-016 Pending value SHALL be copied into the display register only at a frame wrap (tear-free); multiple loads within one frame: last one wins.
REQ-017 load coinciding with a frame wrap SHALL be displayed from the following frame, not the current one.
REQ-018 Mode 00: digit k shows display-register nibble k using hex glyphs 0-F (0=1000000, 1=1111001, ..., A=0001000, F=0001110).
REQ-019 Mode 00 with blank_en=1: digits above the highest nonzero nibble SHALL show 1111111; digit 0 is never blanked (value 0 shows "0").
REQ-020 Mode 01: digits show a 4*N_DIGITS-bit test counter, incremented by 1 at each frame wrap, wrapping modulo 2^(4*N_DIGITS); blank_en ignored.
REQ-021 Mode 10: hex = 1111111, hex_on all ones; divider, scan and capture keep running.
REQ-022 Mode 11: hex = 0000000 on the scanned digit.
REQ-023 mode change SHALL take effect on outputs within 1 cycle, no wait for frame boundary.
REQ-024 Output latency: hex/hex_on reflect scan index and display register with exactly 1 cycle of register delay.

Reset
REQ-025 Asserting rst_n low SHALL immediately force hex=1111111, hex_on all ones, frame_done=0.
REQ-026 Reset SHALL clear divider, scan index, pending, display and test-counter registers to 0.
REQ-027 Reset mid-frame or mid-load discards any pending value; after release scan restarts at digit 0.

Structure
REQ-028 Shared package holds the 16-entry glyph table, blank pattern 1111111, lamp pattern 0000000 and mode encodings.
REQ-029 One sub-module seg_hex_decode (4-bit nibble -> 7-bit active-low glyph, combinational) SHALL be instantiated once on the selected nibble.

Verification (N_DIGITS=4, CLK_DIV=4)
REQ-030 Reset release, mode 00, no load -> hex_on cycles 1110,1101,1011,0111 every 4 cycles; hex=1000000 each digit; frame_done every 16 cycles.
REQ-031 load with data_in=16'h1A3F mid-frame -> old value until wrap, then digits 0..3 show F,3,A,1.
REQ-032 Two loads 16'h0001 then 16'h0002 in one frame, blank_en=1 -> next frame digit 0 = 0100100, digits 1-3 = 1111111.
REQ-033 mode 01 from reset -> frame n shows counter value n; after 65536 frames counter reads 0000.
REQ-034 mode 10 then 11 -> hex_on 1111 and hex 1111111; then scanned digit lit with hex 0000000 on next cycle.
REQ-035 rst_n low at cycle 7 of a frame after load pending -> outputs blank same cycle; after release display 0000, pending value lost.
